// File: rtl/alu_seq_param.sv
// Purpose : parametrised handshaked ALU; add/sub/logic/pack single-cycle, mul/div iterative (1 bit per cycle).
// Latency : out_valid 1 cycle after accept for ops 0,1,4-7; WIDTH+1 cycles for mul (2) and div (3).
// Backpres: result and flags held in DONE until out_valid&out_ready; in_ready only in IDLE.
//
// Ports:
//   clk, rst_n                 clock (rising edge) and asynchronous active-low reset
//   in_valid / in_ready        operation handshake; op, a, b captured on the accept edge
//   op[2:0], a, b              operation select and unsigned WIDTH-bit operands
//   out_valid / out_ready      result handshake
//   result[2*WIDTH-1:0]        result; flag_zero, flag_carry, flag_dz qualify it
//
// Build option: define ALU_SAT_EN to make add/sub saturate instead of wrap.

module alu_seq_param #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 flag_zero,
    output logic                 flag_carry,
    output logic                 flag_dz
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;

    // Held low through reset and set on the first edge after release, so
    // in_ready only rises one edge after rst_n deasserts.
    logic                 started;

    logic [CW-1:0]        cnt;
    // Mul: {partial product high, multiplier shifting out}.
    // Div: {remainder, dividend shifting out / quotient shifting in}.
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     opnd;       // multiplicand (mul) or divisor (div)
    logic                 is_div;
    logic                 dz_pend;

    logic                 accept;
    logic                 iter_op;
    logic                 last_step;

    assign in_ready  = started && (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign iter_op   = (op == 3'd2) || (op == 3'd3);
    assign last_step = (cnt == CNT_ONE);

    // ------------------------------------------------------------------
    // Single-cycle operations, evaluated directly on the input operands
    // ------------------------------------------------------------------
    logic [WIDTH:0]       add_sum;
    logic [WIDTH:0]       sub_dif;
    logic [2*WIDTH-1:0]   quick_res;
    logic                 quick_carry;

    always_comb begin
        add_sum     = {1'b0, a} + {1'b0, b};
        sub_dif     = {1'b0, a} - {1'b0, b};
        quick_res   = '0;
        quick_carry = 1'b0;
        case (op)
            3'd0: begin
                quick_carry = add_sum[WIDTH];
`ifdef ALU_SAT_EN
                if (add_sum[WIDTH]) begin
                    quick_res = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
                end else begin
                    quick_res = {{(WIDTH-1){1'b0}}, add_sum};
                end
`else
                quick_res = {{(WIDTH-1){1'b0}}, add_sum};
`endif
            end
            3'd1: begin
                // Top bit of the (WIDTH+1)-bit difference is the borrow, i.e. a < b.
                quick_carry = sub_dif[WIDTH];
`ifdef ALU_SAT_EN
                if (sub_dif[WIDTH]) begin
                    quick_res = '0;
                end else begin
                    quick_res = {{WIDTH{1'b0}}, sub_dif[WIDTH-1:0]};
                end
`else
                quick_res = {{WIDTH{1'b0}}, sub_dif[WIDTH-1:0]};
`endif
            end
            3'd4:    quick_res = {{WIDTH{1'b0}}, a & b};
            3'd5:    quick_res = {{WIDTH{1'b0}}, a | b};
            3'd6:    quick_res = {{WIDTH{1'b0}}, a ^ b};
            3'd7:    quick_res = {b, a};
            default: quick_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // One iteration of shift-add multiply / restoring divide
    // ------------------------------------------------------------------
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_nxt;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;
    logic [2*WIDTH-1:0]   div_nxt;
    logic [2*WIDTH-1:0]   step_nxt;

    always_comb begin
        // Add the multiplicand into the high half when the multiplier LSB is
        // set, then shift the whole product right; the carry lands in the MSB.
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_nxt = {mul_sum, acc[WIDTH-1:1]};

        // Shift the next dividend bit into the remainder and trial-subtract.
        // The remainder is always below the divisor, so the shifted value fits
        // WIDTH+1 bits and the difference MSB is a clean borrow. A zero divisor
        // never borrows: quotient fills with ones and the remainder ends as a.
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        if (!div_diff[WIDTH]) begin
            div_nxt = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            div_nxt = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end

        step_nxt = is_div ? div_nxt : mul_nxt;
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = iter_op ? BUSY : DONE;
                end
            end
            BUSY: begin
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started    <= 1'b0;
            cnt        <= '0;
            acc        <= '0;
            opnd       <= '0;
            is_div     <= 1'b0;
            dz_pend    <= 1'b0;
            result     <= '0;
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
            flag_dz    <= 1'b0;
        end else begin
            started <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (iter_op) begin
                            is_div  <= (op == 3'd3);
                            dz_pend <= (op == 3'd3) && (b == '0);
                            cnt     <= CNT_LOAD;
                            if (op == 3'd3) begin
                                opnd <= b;
                                acc  <= {{WIDTH{1'b0}}, a};
                            end else begin
                                opnd <= a;
                                acc  <= {{WIDTH{1'b0}}, b};
                            end
                        end else begin
                            result     <= quick_res;
                            flag_zero  <= (quick_res == '0);
                            flag_carry <= quick_carry;
                            flag_dz    <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt - CNT_ONE;
                    acc <= step_nxt;
                    if (last_step) begin
                        result     <= step_nxt;
                        flag_zero  <= (step_nxt == '0);
                        flag_carry <= 1'b0;
                        flag_dz    <= dz_pend;
                    end
                end
                default: begin
                    // DONE: everything held until the result handshake
                end
            endcase
        end
    end

endmodule
